// File: rtl/switch_pkg.sv
// Shared definitions for the switch output-port arbiter.
//   NUM_IN_DEFAULT    : number of input queues sharing the port
//   DATA_W_DEFAULT    : width of one data byte on the serial path
//   STALL_MAX_DEFAULT : consecutive unread-ready cycles before a stall error
//   arb_state_e       : arbiter FSM states (IDLE, XFER)
package switch_pkg;

  localparam int NUM_IN_DEFAULT    = 4;
  localparam int DATA_W_DEFAULT    = 8;
  localparam int STALL_MAX_DEFAULT = 255;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    XFER = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
// Ports:
//   req        in  NUM_IN          request vector
//   last_ptr   in  $clog2(NUM_IN)  index of the previous owner
//   gnt_onehot out NUM_IN          one-hot winner (zero when no request)
//   gnt_idx    out $clog2(NUM_IN)  winner index (zero when no request)
//   gnt_valid  out 1               at least one request present
// The search starts at last_ptr+1 and wraps from NUM_IN-1 to 0, so the
// previous owner has the lowest priority.
module rr_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_IN = NUM_IN_DEFAULT
) (
  input  logic [NUM_IN-1:0]         req,
  input  logic [$clog2(NUM_IN)-1:0] last_ptr,
  output logic [NUM_IN-1:0]         gnt_onehot,
  output logic [$clog2(NUM_IN)-1:0] gnt_idx,
  output logic                      gnt_valid
);

  localparam int IDX_W = $clog2(NUM_IN);

  // First requester after last_ptr in circular order.
  always_comb begin
    gnt_onehot = {NUM_IN{1'b0}};
    gnt_idx    = {IDX_W{1'b0}};
    gnt_valid  = 1'b0;
    for (int off = 1; off <= NUM_IN; off++) begin : scan
      int cand;
      cand = int'(last_ptr) + off;
      if (cand >= NUM_IN) begin
        cand = cand - NUM_IN;
      end else begin
        cand = cand;
      end
      if (!gnt_valid && req[cand]) begin
        gnt_valid        = 1'b1;
        gnt_idx          = IDX_W'(cand);
        gnt_onehot[cand] = 1'b1;
      end else begin
        gnt_valid = gnt_valid;
      end
    end
  end

endmodule

// File: rtl/switch_port_arbiter.sv
// Packet-level round-robin arbiter feeding NUM_IN byte queues into one
// registered output slot.
// Ports:
//   clk, rst    clock and asynchronous active-high reset
//   in_valid    per-queue head byte valid
//   in_data     per-queue head byte, queue i at [i*DATA_W +: DATA_W]
//   in_last     per-queue head byte ends its packet
//   in_pop      one-hot pop strobe to the granted queue (combinational)
//   port_out    registered output byte
//   port_ready  port_out holds a valid byte
//   port_read   consumer takes port_out this cycle
//   grant       index of the current or most recent owner
//   busy        a packet is in progress
//   stall_err   sticky: the consumer left a ready byte unread STALL_MAX cycles
module switch_port_arbiter
  import switch_pkg::*;
#(
  parameter int NUM_IN    = NUM_IN_DEFAULT,
  parameter int DATA_W    = DATA_W_DEFAULT,
  parameter int STALL_MAX = STALL_MAX_DEFAULT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_IN-1:0]         in_valid,
  input  logic [NUM_IN*DATA_W-1:0]  in_data,
  input  logic [NUM_IN-1:0]         in_last,
  output logic [NUM_IN-1:0]         in_pop,
  output logic [DATA_W-1:0]         port_out,
  output logic                      port_ready,
  input  logic                      port_read,
  output logic [$clog2(NUM_IN)-1:0] grant,
  output logic                      busy,
  output logic                      stall_err
);

  localparam int IDX_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(STALL_MAX + 1);
  localparam logic [IDX_W-1:0]  RR_RESET  = IDX_W'(NUM_IN - 1);
  localparam logic [NUM_IN-1:0] OH_RESET  = {{(NUM_IN-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STALL_MAX);
  localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_e          state_r;
  arb_state_e          state_next_s;
  logic                busy_r;
  logic [IDX_W-1:0]    grant_r;
  logic [NUM_IN-1:0]   grant_oh_r;
  logic [IDX_W-1:0]    rr_ptr_r;
  logic [DATA_W-1:0]   port_out_r;
  logic                port_ready_r;
  logic [CNT_W-1:0]    stall_cnt_r;
  logic [CNT_W-1:0]    stall_cnt_next_s;
  logic                stall_err_r;

  logic                slot_free_s;
  logic                pop_s;
  logic                arb_load_s;
  logic                arb_valid_s;
  logic [IDX_W-1:0]    arb_idx_s;
  logic [NUM_IN-1:0]   arb_onehot_s;
  logic                head_valid_s;
  logic                head_last_s;
  logic [DATA_W-1:0]   head_data_s;

  rr_arbiter #(
    .NUM_IN (NUM_IN)
  ) u_rr (
    .req        (in_valid),
    .last_ptr   (rr_ptr_r),
    .gnt_onehot (arb_onehot_s),
    .gnt_idx    (arb_idx_s),
    .gnt_valid  (arb_valid_s)
  );

  // The slot can take a new byte when empty or being drained this cycle.
  assign slot_free_s = !port_ready_r || port_read;

  // Head-of-queue view of the granted queue, muxed by the one-hot grant.
  always_comb begin
    head_valid_s = |(in_valid & grant_oh_r);
    head_last_s  = |(in_last & grant_oh_r);
    head_data_s  = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_IN; i++) begin
      head_data_s = head_data_s | (in_data[i*DATA_W +: DATA_W] & {DATA_W{grant_oh_r[i]}});
    end
  end

  // Next-state logic and the pop strobe.
  always_comb begin
    state_next_s = state_r;
    pop_s        = 1'b0;
    arb_load_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (arb_valid_s) begin
          arb_load_s   = 1'b1;
          state_next_s = XFER;
        end else begin
          state_next_s = IDLE;
        end
      end
      XFER: begin
        // A missing head byte simply waits; there is no timeout.
        if (head_valid_s && slot_free_s) begin
          pop_s = 1'b1;
          if (head_last_s) begin
            state_next_s = IDLE;
          end else begin
            state_next_s = XFER;
          end
        end else begin
          state_next_s = XFER;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    in_pop = grant_oh_r & {NUM_IN{pop_s}};
  end

  // Stall counter next value: counts unread ready cycles, saturating.
  always_comb begin
    if (port_ready_r && !port_read) begin
      if (stall_cnt_r < CNT_MAX) begin
        stall_cnt_next_s = stall_cnt_r + CNT_ONE;
      end else begin
        stall_cnt_next_s = stall_cnt_r;
      end
    end else begin
      stall_cnt_next_s = {CNT_W{1'b0}};
    end
  end

  // FSM state register and its registered busy flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == XFER);
    end
  end

  // Grant capture at arbitration; rr pointer moves only when a packet ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_r    <= {IDX_W{1'b0}};
      grant_oh_r <= OH_RESET;
      rr_ptr_r   <= RR_RESET;
    end else begin
      if (arb_load_s) begin
        grant_r    <= arb_idx_s;
        grant_oh_r <= arb_onehot_s;
      end else begin
        grant_r    <= grant_r;
        grant_oh_r <= grant_oh_r;
      end
      if (pop_s && head_last_s) begin
        rr_ptr_r <= grant_r;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // Output slot: load on pop, empty on read, otherwise hold the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      port_out_r   <= {DATA_W{1'b0}};
      port_ready_r <= 1'b0;
    end else if (pop_s) begin
      port_out_r   <= head_data_s;
      port_ready_r <= 1'b1;
    end else if (port_read) begin
      port_ready_r <= 1'b0;
    end else begin
      port_ready_r <= port_ready_r;
    end
  end

  // Stall counter and the sticky error it raises on reaching STALL_MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      stall_err_r <= 1'b0;
    end else begin
      stall_cnt_r <= stall_cnt_next_s;
      stall_err_r <= stall_err_r | (stall_cnt_next_s == CNT_MAX);
    end
  end

  assign port_out   = port_out_r;
  assign port_ready = port_ready_r;
  assign grant      = grant_r;
  assign busy       = busy_r;
  assign stall_err  = stall_err_r;

endmodule

// File: tb/tb_switch_port_arbiter.sv
// Directed bench for switch_port_arbiter with a packet-level reference model.
module tb_switch_port_arbiter;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int SMAX = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   in_valid;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_last;
  logic [N-1:0]   in_pop;
  logic [W-1:0]   port_out;
  logic           port_ready;
  logic           port_read;
  logic [1:0]     grant;
  logic           busy;
  logic           stall_err;

  always #5 clk = ~clk;

  switch_port_arbiter #(.NUM_IN(N), .DATA_W(W), .STALL_MAX(SMAX)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_pop(in_pop), .port_out(port_out),
    .port_ready(port_ready), .port_read(port_read), .grant(grant),
    .busy(busy), .stall_err(stall_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Source queues (stimulus) and per-queue valid gaps.
  logic [W-1:0] q_data[N][$];
  bit           q_last[N][$];
  bit           gap[N];

  // Reference model: packet owner, last finished owner, output slot, stall.
  bit           m_busy;
  int           m_grant;
  int           m_rr;
  bit           m_ready;
  logic [W-1:0] m_out;
  int           m_cnt;
  bit           m_err;

  // Observation log, one entry per step.
  int           step_no = 0;
  bit           obs_ready[$];
  logic [W-1:0] obs_out[$];
  int           obs_grant[$];
  bit           obs_err[$];
  logic [W-1:0] acc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (step %0d)", name, act, exp, step_no);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_grant = 0; m_rr = N - 1; m_ready = 1'b0;
    m_out = '0; m_cnt = 0; m_err = 1'b0;
  endtask

  task automatic push_byte(input int q, input logic [W-1:0] d, input bit last);
    q_data[q].push_back(d);
    q_last[q].push_back(last);
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < N; i++) begin
      if (q_data[i].size() > 0 && !gap[i]) begin
        in_valid[i] = 1'b1;
        in_data[i*W +: W] = q_data[i][0];
        in_last[i] = q_last[i][0];
      end else begin
        in_valid[i] = 1'b0;
        in_data[i*W +: W] = '0;
        in_last[i] = 1'b0;
      end
    end
  endtask

  // One clock cycle: drive, compare every output against the model, advance.
  task automatic step(input bit rd);
    logic [N-1:0] exp_pop;
    bit old_ready;
    bit found;
    int g;
    @(negedge clk);
    port_read = rd;
    drive_inputs();
    #1;
    exp_pop = '0;
    if (m_busy && in_valid[m_grant] && (!m_ready || rd)) exp_pop[m_grant] = 1'b1;
    check("in_pop", in_pop, exp_pop);
    check("port_ready", port_ready, m_ready);
    check("port_out", port_out, m_out);
    check("grant", grant, m_grant);
    check("busy", busy, m_busy);
    check("stall_err", stall_err, m_err);
    obs_ready.push_back(port_ready);
    obs_out.push_back(port_out);
    obs_grant.push_back(int'(grant));
    obs_err.push_back(stall_err);
    if (port_ready && rd) acc.push_back(port_out);
    old_ready = m_ready;
    if (m_busy) begin
      if (exp_pop != '0) begin
        m_out = in_data[m_grant*W +: W];
        m_ready = 1'b1;
        if (in_last[m_grant]) begin
          m_busy = 1'b0;
          m_rr = m_grant;
        end
      end else if (rd) begin
        m_ready = 1'b0;
      end
    end else begin
      if (rd) m_ready = 1'b0;
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        g = (m_rr + k) % N;
        if (!found && in_valid[g]) begin
          found = 1'b1;
          m_grant = g;
          m_busy = 1'b1;
        end
      end
    end
    if (old_ready && !rd) begin
      if (m_cnt < SMAX) m_cnt++;
    end else begin
      m_cnt = 0;
    end
    if (m_cnt == SMAX) m_err = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (in_pop[i] && q_data[i].size() > 0) begin
        void'(q_data[i].pop_front());
        void'(q_last[i].pop_front());
      end
    end
    step_no++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    port_read = 1'b0;
    #1;
    check("rst_in_pop", in_pop, 0);
    @(posedge clk);
    #1;
    check("rst_port_ready", port_ready, 0);
    check("rst_port_out", port_out, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_stall_err", stall_err, 0);
    check("rst_in_pop_edge", in_pop, 0);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic drain(input int budget);
    int k;
    bit pending;
    k = 0;
    pending = 1'b1;
    while (pending && k < budget) begin
      step(1'b1);
      k++;
      pending = m_busy || port_ready;
      for (int i = 0; i < N; i++) if (q_data[i].size() > 0) pending = 1'b1;
    end
    check("drain_done", (k < budget), 1);
  endtask

  task automatic check_stream(input string name, input logic [W-1:0] exp[$]);
    check({name, "_len"}, acc.size(), exp.size());
    for (int k = 0; k < exp.size(); k++) begin
      if (k < acc.size()) check(name, acc[k], exp[k]);
    end
  endtask

  initial begin
    int s;
    rst = 1'b1;
    port_read = 1'b0;
    in_valid = '0; in_data = '0; in_last = '0;
    for (int i = 0; i < N; i++) gap[i] = 1'b0;
    model_reset();
    do_reset();

    // Single queue, three bytes, consumer always reading.
    push_byte(0, 8'h11, 1'b0); push_byte(0, 8'h22, 1'b0); push_byte(0, 8'h33, 1'b1);
    s = step_no;
    acc.delete();
    for (int k = 0; k < 7; k++) step(1'b1);
    check("single_lat_r0", obs_ready[s], 0);
    check("single_lat_r1", obs_ready[s+1], 0);
    check("single_lat_r2", obs_ready[s+2], 1);
    check("single_b0", obs_out[s+2], 8'h11);
    check("single_b1", obs_out[s+3], 8'h22);
    check("single_b2", obs_out[s+4], 8'h33);
    check("single_drop", obs_ready[s+5], 0);
    check_stream("single_stream", '{8'h11, 8'h22, 8'h33});

    // Contention from reset: all four queues, two-byte packets.
    do_reset();
    acc.delete();
    for (int q = 0; q < N; q++) begin
      push_byte(q, 8'(q*16 + 1), 1'b0);
      push_byte(q, 8'(q*16 + 2), 1'b1);
    end
    drain(80);
    check_stream("contend", '{8'h01, 8'h02, 8'h11, 8'h12, 8'h21, 8'h22, 8'h31, 8'h32});

    // Backpressure: five unread cycles mid-packet.
    acc.delete();
    push_byte(0, 8'h41, 1'b0); push_byte(0, 8'h42, 1'b0);
    push_byte(0, 8'h43, 1'b0); push_byte(0, 8'h44, 1'b1);
    s = step_no;
    for (int k = 0; k < 4; k++) step(1'b1);
    for (int k = 0; k < 5; k++) step(1'b0);
    for (int k = 4; k < 9; k++) begin
      check("bp_hold_out", obs_out[s+k], 8'h43);
      check("bp_hold_ready", obs_ready[s+k], 1);
    end
    check("bp_no_pop", q_data[0].size(), 1);
    drain(40);
    check_stream("bp_stream", '{8'h41, 8'h42, 8'h43, 8'h44});
    check("bp_stall_err", stall_err, 1);

    // Stall detection at STALL_MAX=4 unread ready cycles.
    do_reset();
    push_byte(0, 8'h51, 1'b0); push_byte(0, 8'h52, 1'b1);
    s = step_no;
    for (int k = 0; k < 7; k++) step(1'b0);
    check("stall_ready", obs_ready[s+2], 1);
    check("stall_err_3", obs_err[s+5], 0);
    check("stall_err_4", obs_err[s+6], 1);
    drain(40);
    check("stall_sticky", stall_err, 1);

    // Source gap on q2 while q1 waits.
    acc.delete();
    push_byte(2, 8'h61, 1'b0); push_byte(2, 8'h62, 1'b0);
    push_byte(2, 8'h63, 1'b0); push_byte(2, 8'h64, 1'b1);
    s = step_no;
    for (int k = 0; k < 3; k++) step(1'b1);
    push_byte(1, 8'h71, 1'b0); push_byte(1, 8'h72, 1'b1);
    gap[2] = 1'b1;
    for (int k = 0; k < 3; k++) step(1'b1);
    gap[2] = 1'b0;
    for (int k = 3; k < 6; k++) check("gap_grant", obs_grant[s+k], 2);
    check("gap_drained_a", obs_ready[s+4], 0);
    check("gap_drained_b", obs_ready[s+5], 0);
    check("gap_q1_waits", q_data[1].size(), 2);
    drain(40);
    check_stream("gap_stream", '{8'h61, 8'h62, 8'h63, 8'h64, 8'h71, 8'h72});

    // Reset mid-packet on q1, with q2 also requesting afterwards.
    push_byte(1, 8'h81, 1'b0); push_byte(1, 8'h82, 1'b0); push_byte(1, 8'h83, 1'b1);
    s = step_no;
    for (int k = 0; k < 3; k++) step(1'b1);
    check("rstmid_grant_pre", obs_grant[s+1], 1);
    push_byte(2, 8'h91, 1'b0); push_byte(2, 8'h92, 1'b1);
    do_reset();
    check("rstmid_left", q_data[1].size(), 1);
    acc.delete();
    s = step_no;
    for (int k = 0; k < 2; k++) step(1'b1);
    check("rstmid_regrant", obs_grant[s+1], 1);
    drain(40);
    check_stream("rstmid_stream", '{8'h83, 8'h91, 8'h92});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
